// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the single VGA pixel-write port between NREQ requesters
// (tail erase, head draw, food draw). One pixel is served per grant: the
// winner's coordinates are latched, plot is held for HOLD cycles, and the
// winner then receives a one-cycle ack. Off-screen pixels are clipped: they
// skip the plot window and are acknowledged straight away.
//
// Build option: define PLOT_ARB_RR_EN to replace fixed-priority arbitration
// (lowest index wins) with round-robin arbitration starting at rr_ptr.
module plot_arbiter #(
  parameter int NREQ  = 3,
  parameter int HOLD  = 1,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_x,
  input  logic [NREQ*7-1:0] req_y,
  input  logic [NREQ*3-1:0] req_colour,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        x_out,
  output logic [6:0]        y_out,
  output logic [2:0]        colour_out,
  output logic              plot,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [7:0] X_LIM = 8'(X_MAX);
  localparam logic [6:0] Y_LIM = 7'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   hold_cnt;
  logic [IW-1:0]   win_q;

  logic            found;
  logic [IW-1:0]   win;
  logic [7:0]      x_sel;
  logic [6:0]      y_sel;
  logic [2:0]      c_sel;
  logic            in_range;

`ifdef PLOT_ARB_RR_EN
  logic [IW-1:0]   rr_ptr;
  int              idx;

  // Pick the first requester at or after rr_ptr, wrapping round, and mux its pixel
  always_comb begin
    found = 1'b0;
    win   = '0;
    x_sel = '0;
    y_sel = '0;
    c_sel = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
        x_sel = req_x[8*idx +: 8];
        y_sel = req_y[7*idx +: 7];
        c_sel = req_colour[3*idx +: 3];
      end
    end
  end

  // Pointer one past the given winner, wrapping at NREQ
  function automatic logic [IW-1:0] after(input logic [IW-1:0] w);
    if (w == IW'(NREQ - 1)) return '0;
    return w + 1'b1;
  endfunction

  // Advance the round-robin pointer whenever a grant enters ACK, clipped or not
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (state == IDLE && found && !in_range) begin
      rr_ptr <= after(win);
    end else if (state == PLOT && hold_cnt == '0) begin
      rr_ptr <= after(win_q);
    end
  end
`else
  // Pick the lowest-indexed active requester and mux its pixel
  always_comb begin
    found = 1'b0;
    win   = '0;
    x_sel = '0;
    y_sel = '0;
    c_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        win   = IW'(k);
        x_sel = req_x[8*k +: 8];
        y_sel = req_y[7*k +: 7];
        c_sel = req_colour[3*k +: 3];
      end
    end
  end
`endif

  // Unsigned on-screen test of the pixel about to be granted
  always_comb begin
    in_range = (x_sel <= X_LIM) && (y_sel <= Y_LIM);
  end

  // Grant FSM: capture winner, hold plot for HOLD cycles, then pulse its ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      win_q      <= '0;
      ack        <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack  <= '0;
          plot <= 1'b0;
          if (found) begin
            x_out      <= x_sel;
            y_out      <= y_sel;
            colour_out <= c_sel;
            win_q      <= win;
            busy       <= 1'b1;
            if (in_range) begin
              state    <= PLOT;
              plot     <= 1'b1;
              hold_cnt <= CW'(HOLD - 1);
            end else begin
              state    <= ACK;
              ack      <= '0;
              ack[win] <= 1'b1;
            end
          end
        end
        PLOT: begin
          if (hold_cnt == '0) begin
            state      <= ACK;
            plot       <= 1'b0;
            ack        <= '0;
            ack[win_q] <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          ack   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack   <= '0;
          plot  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed bench for plot_arbiter. Two instances share the
// same stimulus: d1 with HOLD=1 and d3 with HOLD=3. Expected values are
// hand-derived from the grant timeline; PLOT_ARB_RR_EN selects the
// round-robin expectations.
module tb_plot_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;

  logic [2:0]  ack1, ack3;
  logic [7:0]  x1, x3;
  logic [6:0]  y1, y3;
  logic [2:0]  c1, c3;
  logic        plot1, plot3, busy1, busy3;

  int n_checks;
  int n_errors;
  logic [2:0] exp_seq [6];

  plot_arbiter #(.NREQ(3), .HOLD(1), .X_MAX(159), .Y_MAX(119)) d1 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .ack(ack1), .x_out(x1), .y_out(y1),
    .colour_out(c1), .plot(plot1), .busy(busy1)
  );

  plot_arbiter #(.NREQ(3), .HOLD(3), .X_MAX(159), .Y_MAX(119)) d3 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .ack(ack3), .x_out(x3), .y_out(y3),
    .colour_out(c3), .plot(plot3), .busy(busy3)
  );

  // Free-running 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, flag it on mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set the pixel presented by requester i
  task automatic applyStimulus(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_x[8*i +: 8]      = x;
    req_y[7*i +: 7]      = y;
    req_colour[3*i +: 3] = c;
  endtask

  // Reset both instances and leave them idle
  task automatic doReset();
    reset_n = 1'b0;
    req     = 3'b000;
    tick();
    tick();
    #2 reset_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    req_x      = '0;
    req_y      = '0;
    req_colour = '0;

    // 1. reset with all requests active: everything quiet
    reset_n = 1'b0;
    req     = 3'b111;
    applyStimulus(0, 8'd1, 7'd1, 3'd1);
    tick();
    tick();
    checkOutput("rst_ack",  {29'b0, ack1}, 32'h0);
    checkOutput("rst_plot", {31'b0, plot1}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy1}, 32'h0);
    checkOutput("rst_x",    {24'b0, x1}, 32'h0);
    checkOutput("rst_y",    {25'b0, y1}, 32'h0);
    checkOutput("rst_col",  {29'b0, c1}, 32'h0);
    checkOutput("rst_busy3", {31'b0, busy3}, 32'h0);
    req = 3'b000;
    #2 reset_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_busy", {31'b0, busy1}, 32'h0);
    checkOutput("idle_plot", {31'b0, plot1}, 32'h0);

    // 2/3. single request from requester 1 (d1: HOLD=1, d3: HOLD=3)
    applyStimulus(1, 8'd10, 7'd20, 3'b101);
    req = 3'b010;
    tick();
    checkOutput("h1_plot",  {31'b0, plot1}, 32'h1);
    checkOutput("h1_x",     {24'b0, x1}, 32'd10);
    checkOutput("h1_y",     {25'b0, y1}, 32'd20);
    checkOutput("h1_col",   {29'b0, c1}, 32'd5);
    checkOutput("h1_ack0",  {29'b0, ack1}, 32'h0);
    checkOutput("h3_plot1", {31'b0, plot3}, 32'h1);
    checkOutput("h3_busy1", {31'b0, busy3}, 32'h1);
    applyStimulus(1, 8'd99, 7'd99, 3'b010);
    tick();
    checkOutput("h1_plot_off", {31'b0, plot1}, 32'h0);
    checkOutput("h1_ack",      {29'b0, ack1}, 32'h2);
    checkOutput("h3_plot2",    {31'b0, plot3}, 32'h1);
    checkOutput("h3_xstable",  {24'b0, x3}, 32'd10);
    req = 3'b000;
    tick();
    checkOutput("h1_ack_gone", {29'b0, ack1}, 32'h0);
    checkOutput("h1_idle",     {31'b0, busy1}, 32'h0);
    checkOutput("h3_plot3",    {31'b0, plot3}, 32'h1);
    checkOutput("h3_ack_early", {29'b0, ack3}, 32'h0);
    tick();
    checkOutput("h3_plot_off", {31'b0, plot3}, 32'h0);
    checkOutput("h3_ack",      {29'b0, ack3}, 32'h2);
    checkOutput("h3_busy4",    {31'b0, busy3}, 32'h1);
    tick();
    checkOutput("h3_busy_end", {31'b0, busy3}, 32'h0);
    checkOutput("h3_ack_gone", {29'b0, ack3}, 32'h0);
    checkOutput("h1_hold_x",   {24'b0, x1}, 32'd10);

    // 4. fixed priority (default build) / round-robin: each drops on its ack
    doReset();
    applyStimulus(0, 8'd1, 7'd2, 3'd3);
    applyStimulus(1, 8'd4, 7'd5, 3'd6);
    applyStimulus(2, 8'd7, 7'd8, 3'd1);
    req = 3'b111;
    tick();
    checkOutput("p0_x",   {24'b0, x1}, 32'd1);
    checkOutput("p0_y",   {25'b0, y1}, 32'd2);
    tick();
    checkOutput("p0_ack", {29'b0, ack1}, 32'h1);
    req[0] = 1'b0;
    tick();
    tick();
    checkOutput("p1_x",   {24'b0, x1}, 32'd4);
    checkOutput("p1_col", {29'b0, c1}, 32'd6);
    tick();
    checkOutput("p1_ack", {29'b0, ack1}, 32'h2);
    req[1] = 1'b0;
    tick();
    tick();
    checkOutput("p2_x",    {24'b0, x1}, 32'd7);
    checkOutput("p2_plot", {31'b0, plot1}, 32'h1);
    tick();
    checkOutput("p2_ack",  {29'b0, ack1}, 32'h4);
    req[2] = 1'b0;

    // 4/5. all requests held continuously
    doReset();
`ifdef PLOT_ARB_RR_EN
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      tick();
      checkOutput($sformatf("held_ack%0d", i), {29'b0, ack1}, {29'b0, exp_seq[i]});
      tick();
    end
    req = 3'b000;

    // 6. clipped pixel: no plot, ack one cycle after grant
    doReset();
    applyStimulus(2, 8'd160, 7'd5, 3'd2);
    req = 3'b100;
    tick();
    checkOutput("clip_plot",  {31'b0, plot1}, 32'h0);
    checkOutput("clip_ack",   {29'b0, ack1}, 32'h4);
    checkOutput("clip_busy",  {31'b0, busy1}, 32'h1);
    checkOutput("clip_plot3", {31'b0, plot3}, 32'h0);
    checkOutput("clip_ack3",  {29'b0, ack3}, 32'h4);
    req = 3'b000;
    tick();
    checkOutput("clip_ack_gone", {29'b0, ack1}, 32'h0);
    checkOutput("clip_idle",     {31'b0, busy1}, 32'h0);

    // 6. asynchronous reset in the middle of a plot window
    applyStimulus(0, 8'd30, 7'd40, 3'd7);
    req = 3'b001;
    tick();
    checkOutput("abort_pre_plot", {31'b0, plot3}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_plot",  {31'b0, plot3}, 32'h0);
    checkOutput("abort_plot1", {31'b0, plot1}, 32'h0);
    req = 3'b000;
    tick();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("abort_noack%0d", i), {29'b0, ack3}, 32'h0);
    end
    checkOutput("abort_idle", {31'b0, busy3}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
